bsg_pipeline_share_rr: RTL
==========================

Name: bsg_pipeline_share_rr

Overview:
- Shares one in-order ready/valid pipeline (e.g. a stall-collapse pipeline) between els_p requesters.
- Round-robin arbitration chooses which request enters the pipeline.
- A tag FIFO records the issuing requester of each in-flight item, in order.
- Each pipeline output is routed back to the requester named by the head tag; the FIFO bounds in-flight items to tag_els_p.

Parameters:
- els_p, 4, number of requesters (>=2).
- width_p, 16, payload width in both directions.
- tag_els_p, 4, maximum in-flight items; tag FIFO depth (>=1, any value).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_v_i  in  els_p  per-requester valid.
- req_data_i  in  els_p*width_p  per-requester payload, requester i at bits [i*width_p +: width_p].
- req_ready_and_o  out  els_p  per-requester accept.
- pipe_v_o  out  1  valid into shared pipeline.
- pipe_data_o  out  width_p  payload of granted requester.
- pipe_ready_and_i  in  1  pipeline input ready.
- pipe_v_i  in  1  pipeline output valid.
- pipe_data_i  in  width_p  pipeline output payload.
- pipe_ready_and_o  out  1  ready to pipeline output.
- resp_v_o  out  els_p  one-hot response valid.
- resp_data_o  out  width_p  response payload, shared by all requesters (= pipe_data_i).
- resp_ready_and_i  in  els_p  per-requester response ready.
- in_flight_o  out  clog2(tag_els_p+1)  current tag FIFO occupancy.

Behaviour:
- State: rr pointer last_r (clog2(els_p) bits); tag FIFO with rd/wr pointers and count.
- Reset (reset_n_i low, asynchronous):
  - last_r = els_p-1, so requester 0 has first priority.
  - FIFO empty; in_flight_o = 0.
  - While reset is asserted, all outputs are forced low: pipe_v_o, req_ready_and_o, resp_v_o, pipe_ready_and_o.
- Issue side, combinational:
  - full = (count == tag_els_p).
  - grant = first requester with req_v_i set, scanning last_r+1, last_r+2, ... mod els_p.
  - pipe_v_o = |req_v_i & ~full.
  - pipe_data_o = payload of the grant; zeros when there is no grant.
  - req_ready_and_o[g] = pipe_ready_and_i & ~full, for the granted g only; all other bits 0.
  - The grant depends only on req_v_i and last_r, never on pipe_ready_and_i.
- Issue transfer (pipe_v_o & pipe_ready_and_i): push g into the tag FIFO; last_r <= g.
  - No transfer: last_r holds, so a stalled grant stays stable until it is accepted (no valid-withdrawal hazard).
- Full blocks issue even in a cycle where a pop occurs. There is no return-to-issue combinational path.
- Return side, combinational:
  - h = head tag; empty = (count == 0).
  - resp_v_o = onehot(h) when pipe_v_i & ~empty; else 0.
  - pipe_ready_and_o = resp_ready_and_i[h] & ~empty.
  - A response with resp_ready_and_i[h] low stalls the pipeline; there is no bypass for other requesters.
- Return transfer (pipe_v_i & pipe_ready_and_o): pop the FIFO.
- Count update:
  - Push and pop in the same cycle: count unchanged; both pointers advance; wrap at tag_els_p-1 -> 0.
- Latency: zero added cycles in either direction; the block is purely steering plus bookkeeping.
- Error: pipe_v_i while empty is a protocol violation.
  - pipe_ready_and_o stays 0.
  - A nonsynth assertion fires.
- Assertion: count never exceeds tag_els_p.
- Reset mid-operation:
  - In-flight tags are discarded.
  - The pipeline must be reset by the same reset.

Decomposition:
- Shared package bsg_pipeline_share_pkg holds:
  - the tag-width function (clog2 of els_p, minimum 1);
  - a typedef for the response-routing struct {tag, v}, reused by sibling sharers.
- One sub-module: bsg_pipeline_share_tag_fifo.
  - Depth tag_els_p, width = tag width.
  - Interface: push/pop/data/full/empty/count.
  - Asynchronous active-low reset.
- The round-robin scan stays inline.

Test Plan (els_p=4, width_p=16, tag_els_p=4):
- All four req_v_i=1, pipe_ready_and_i=1, pipeline latency 2, all resp_ready=1 -> grants 0,1,2,3,0,...; resp_v_o follows 0001,0010,0100,1000 two cycles later, with data matching each requester.
- Only requester 2 valid, pipeline output never returns -> exactly 4 accepts, then pipe_v_o=0 and in_flight_o=4; the first return re-enables issue on the following cycle.
- pipe_ready_and_i=0 for 3 cycles with requesters 1 and 3 valid -> grant stays 1 and pipe_data_o stays stable; when ready rises, 1 is accepted, then 3.
- Response for requester 1 at head with resp_ready_and_i[1]=0 for 5 cycles -> pipe_ready_and_o=0 and no pop for 5 cycles; the pop occurs when ready rises.
- Push and pop in the same cycle at count=2 -> count stays 2; pointers wrap correctly across 10 consecutive items.
- Assert reset_n_i mid-stream with 3 items in flight -> outputs go low immediately, in_flight_o=0, and requester 0 is granted first after release.

Source files
------------

// File: rtl/bsg_pipeline_share_pkg.sv
// Shared definitions for pipeline sharers.
//   tag_width(els) : bits needed to name one of els requesters (minimum 1)
//   route_t        : response-routing record {tag, v} used on the return side
package bsg_pipeline_share_pkg;

  // Widest requester tag any sharer routes through route_t.
  localparam int ROUTE_TAG_W_MAX = 8;

  function automatic int tag_width(input int els);
    return (els <= 2) ? 1 : $clog2(els);
  endfunction

  typedef struct packed {
    logic [ROUTE_TAG_W_MAX-1:0] tag;
    logic                       v;
  } route_t;

endpackage

// File: rtl/bsg_pipeline_share_tag_fifo.sv
// In-order tag FIFO recording which requester issued each in-flight item.
//   clk_i, reset_n_i : clock, async active-low reset (empties the FIFO)
//   push_i, data_i   : enqueue a tag (caller never pushes when full)
//   pop_i            : dequeue the head (caller never pops when empty)
//   data_o           : head tag
//   full_o, empty_o  : occupancy flags
//   count_o          : occupancy, 0..els_p
module bsg_pipeline_share_tag_fifo
  import bsg_pipeline_share_pkg::*;
#(
  parameter  int els_p   = 4,
  parameter  int width_p = 2,
  localparam int CNT_W   = $clog2(els_p + 1),
  localparam int PTR_W   = tag_width(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [width_p-1:0] r_mem [els_p];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(els_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries no reset; only pointers/count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= f_next(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CNT_W'(els_p));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    r_count <= CNT_W'(els_p));
`endif

endmodule

// File: rtl/bsg_pipeline_share_rr.sv
// Shares one in-order ready/valid pipeline among els_p requesters.
// Round-robin picks the issuing requester; a tag FIFO remembers issue order
// so each pipeline output is steered back to its originator. Zero added
// latency either way: pure steering plus bookkeeping.
//   clk_i, reset_n_i           : clock, async active-low reset
//   req_v_i/req_data_i         : per-requester requests (i at [i*width_p +: width_p])
//   req_ready_and_o            : accept, only ever on the granted requester
//   pipe_v_o/pipe_data_o       : into the shared pipeline
//   pipe_ready_and_i           : pipeline input ready
//   pipe_v_i/pipe_data_i       : out of the shared pipeline
//   pipe_ready_and_o           : ready to pipeline output
//   resp_v_o/resp_data_o       : one-hot response valid, shared payload
//   resp_ready_and_i           : per-requester response ready
//   in_flight_o                : tag FIFO occupancy
module bsg_pipeline_share_rr
  import bsg_pipeline_share_pkg::*;
#(
  parameter int els_p     = 4,
  parameter int width_p   = 16,
  parameter int tag_els_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           req_v_i,
  input  logic [els_p*width_p-1:0]   req_data_i,
  output logic [els_p-1:0]           req_ready_and_o,
  output logic                       pipe_v_o,
  output logic [width_p-1:0]         pipe_data_o,
  input  logic                       pipe_ready_and_i,
  input  logic                       pipe_v_i,
  input  logic [width_p-1:0]         pipe_data_i,
  output logic                       pipe_ready_and_o,
  output logic [els_p-1:0]           resp_v_o,
  output logic [width_p-1:0]         resp_data_o,
  input  logic [els_p-1:0]           resp_ready_and_i,
  output logic [$clog2(tag_els_p+1)-1:0] in_flight_o
);

  localparam int TAG_W = tag_width(els_p);
  localparam int CNT_W = $clog2(tag_els_p + 1);

  logic [TAG_W-1:0] r_last;
  logic [TAG_W-1:0] w_grant;
  logic             w_grant_v;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [TAG_W-1:0] w_head;
  logic [els_p-1:0] w_head_oh;
  route_t           w_route;

  // ---- issue side ----

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  // Deliberately independent of pipe_ready_and_i: a stalled grant holds.
  always_comb begin
    w_grant_v = 1'b0;
    w_grant   = '0;
    for (int k = 1; k <= els_p; k++) begin
      if (!w_grant_v && req_v_i[(int'(r_last) + k) % els_p]) begin
        w_grant_v = 1'b1;
        w_grant   = TAG_W'((int'(r_last) + k) % els_p);
      end
    end
  end

  // Full blocks issue even when a pop lands in the same cycle; this keeps
  // the return path out of the issue path combinationally.
  assign pipe_v_o    = reset_n_i & w_grant_v & ~w_full;
  assign pipe_data_o = w_grant_v ? req_data_i[int'(w_grant)*width_p +: width_p]
                                 : '0;
  assign w_push      = pipe_v_o & pipe_ready_and_i;

  always_comb begin
    req_ready_and_o = '0;
    for (int i = 0; i < els_p; i++) begin
      if (w_grant_v && (w_grant == TAG_W'(i)))
        req_ready_and_o[i] = reset_n_i & pipe_ready_and_i & ~w_full;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_last <= TAG_W'(els_p - 1);
    else if (w_push) r_last <= w_grant;
  end

  // ---- bookkeeping ----

  bsg_pipeline_share_tag_fifo #(
    .els_p   (tag_els_p),
    .width_p (TAG_W)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (w_push),
    .data_i    (w_grant),
    .pop_i     (w_pop),
    .data_o    (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .count_o   (in_flight_o)
  );

  // ---- return side ----

  assign w_route.tag = ROUTE_TAG_W_MAX'(w_head);
  assign w_route.v   = reset_n_i & pipe_v_i & ~w_empty;

  always_comb begin
    w_head_oh = '0;
    for (int i = 0; i < els_p; i++)
      w_head_oh[i] = (w_route.tag == ROUTE_TAG_W_MAX'(i));
  end

  // Head-of-line blocking is inherent: only the head's owner can drain.
  assign resp_v_o         = w_route.v ? w_head_oh : '0;
  assign resp_data_o      = pipe_data_i;
  assign pipe_ready_and_o = reset_n_i & ~w_empty & |(resp_ready_and_i & w_head_oh);
  assign w_pop            = pipe_v_i & pipe_ready_and_o;

`ifndef SYNTHESIS
  a_no_orphan_return: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(pipe_v_i && w_empty));
  a_tag_fits: assert property (@(posedge clk_i) TAG_W <= ROUTE_TAG_W_MAX);
`endif

endmodule
